im_program_loader: RTL
======================

# im_program_loader

Boot-time program loader upstream of the pipelined core. It accepts a byte stream over a valid/ready handshake and assembles 16-bit instruction words. It writes those words sequentially into the instruction-memory write port, then verifies an XOR checksum. The core is held in reset until a load completes with a correct checksum, so IF never fetches a partially written image.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory address width; capacity MAX_WORDS = 2**ADDR_W.

Ports:
- clk, in, 1, single clock.
- reset, in, 1, synchronous, active-high.
- in_valid, in, 1, source has a byte.
- in_byte, in, 8, stream byte.
- in_ready, out, 1, loader accepts a byte; transfer occurs when in_valid & in_ready.
- reload, in, 1, one-cycle request to start a new load; honoured only in RUN or ERROR.
- im_we, out, 1, instruction-memory write enable, one-cycle pulse per word.
- im_addr, out, ADDR_W, write address.
- im_wdata, out, 16, write data.
- core_reset, out, 1, drives the core's reset; high except in RUN.
- load_done, out, 1, image loaded and verified.
- err_len, out, 1, header count exceeds MAX_WORDS.
- err_csum, out, 1, checksum mismatch.

## Operation
- Stream format, in order:
  - 2-byte header N, high byte first.
  - N words, each high byte then low byte.
  - 1 checksum byte equal to the XOR of all 2N payload bytes. Header bytes are excluded from the checksum.
- States: HDR_HI, HDR_LO, DATA_HI, DATA_LO, CHECK, RUN, ERROR. Reset state is HDR_HI.
- HDR_HI: accept a byte, store it as N[15:8], go to HDR_LO.
- HDR_LO: accept a byte, store it as N[7:0], then:
  - N > MAX_WORDS: go to ERROR and set err_len.
  - N == 0: go to CHECK.
  - Otherwise: go to DATA_HI.
- DATA_HI: accept a byte, latch it as the high byte, XOR it into csum, go to DATA_LO.
- DATA_LO: accept a byte, XOR it into csum, and issue a write {hi, byte} at word index wcnt. Increment wcnt. If the new wcnt == N, go to CHECK; otherwise go to DATA_HI.
- CHECK: accept a byte.
  - byte == csum: go to RUN and set load_done.
  - Otherwise: go to ERROR and set err_csum.
- RUN: in_ready=0, core_reset=0. reload → HDR_HI, and clears load_done, wcnt and csum.
- ERROR: in_ready=0, core_reset=1, error flag held. reload → HDR_HI, and clears the error flags, wcnt and csum.
- in_ready=1 in HDR_HI, HDR_LO, DATA_HI, DATA_LO and CHECK. No byte is consumed unless in_valid & in_ready. Idle cycles (in_valid=0) leave state and counters unchanged.
- reload asserted in any loading state is ignored.
- wcnt is 17 bits wide so N = MAX_WORDS is legal; the last word is written at address MAX_WORDS-1 and the address never wraps. im_addr = wcnt[ADDR_W-1:0] at write time.
- Load words not written by the current image keep their old contents; the loader never clears memory.

## Timing
- Reset values:
  - in_ready=0 while reset is high; 1 from the first cycle after reset is released.
  - im_we=0, im_addr=0, im_wdata=0.
  - core_reset=1, load_done=0, err_len=0, err_csum=0.
- Write latency: the low byte is accepted in cycle t. im_we, im_addr and im_wdata are registered and valid in cycle t+1, for exactly one cycle. Back-to-back words produce writes at most every 2 cycles.
- Completion: the checksum byte is accepted in cycle t. In cycle t+1, either core_reset=0 and load_done=1, or err_csum=1. core_reset deasserts only after the final im_we has completed.
- err_len rises in the cycle after the header low byte is accepted.
- reset mid-load: the next cycle is in HDR_HI with wcnt=0, csum=0, im_we=0 and core_reset=1. A pending write whose registered outputs have not yet appeared is dropped.
- reload in RUN: core_reset=1 and in_ready=1 in the next cycle.

## Structure
- Package im_loader_pkg holds:
  - the state enum loader_state_t;
  - HDR_BYTES=2 and CSUM_BYTES=1;
  - the helper function max_words(ADDR_W).
- One sub-module, loader_csum: an 8-bit XOR accumulator with clear and enable inputs. The main module instantiates it and contains the FSM, the word assembler and the write-port registers.

## Test plan
- Normal load, ADDR_W=8: bytes 00 02 12 34 AB CD 40.
  - Writes [0]=0x1234 and [1]=0xABCD, each im_we one cycle wide.
  - After the checksum byte, load_done=1 and core_reset=0.
  - in_ready=0 afterwards.
- Backpressure: the same stream with in_valid low for 3 cycles between every byte. Identical writes and result; no duplicate im_we.
- Zero length: bytes 00 00 00 → no im_we, load_done=1. Bytes 00 00 5A → err_csum=1, core_reset stays 1.
- Overflow: header 01 01 with ADDR_W=8.
  - err_len=1 one cycle after the second byte, in_ready=0, no im_we.
  - Boundary case: header 01 00 followed by 256 words is accepted; the last write is at address 0xFF.
- Bad checksum, then reload:
  - Stream 00 01 12 34 00 → write [0]=0x1234, then err_csum=1.
  - reload pulse followed by 00 01 55 66 33 → [0]=0x5566, load_done=1, err_csum=0.
- Mid-load reset: assert reset after 00 02 12 34 AB, then send a fresh 00 01 77 88 FF.
  - [0]=0x7788 is written; no write to address 1; load_done=1.

Source files
------------

// File: rtl/im_program_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package im_loader_pkg;

  // Loader sequencing states, in stream order followed by the two terminal states.
  typedef enum logic [2:0] {
    HDR_HI  = 3'd0,
    HDR_LO  = 3'd1,
    DATA_HI = 3'd2,
    DATA_LO = 3'd3,
    CHECK   = 3'd4,
    RUN     = 3'd5,
    ERROR   = 3'd6
  } loader_state_t;

  // Framing overhead around the payload: 16-bit word count and one checksum byte.
  localparam int HDR_BYTES  = 2;
  localparam int CSUM_BYTES = 1;

  // Word counter width; one bit wider than the header so N = 2**16 would still fit.
  localparam int WCNT_W = 17;

  // Instruction-memory capacity in words for a given address width.
  function automatic logic [WCNT_W-1:0] max_words(input int addr_w);
    max_words = {{(WCNT_W-1){1'b0}}, 1'b1} << addr_w;
  endfunction

endpackage

// File: rtl/im_program_loader_csum.sv
// 8-bit XOR accumulator over the payload bytes of one image.
module loader_csum
  import im_loader_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] csum
);

  logic [7:0] acc_reg;

  // Clear wins over accumulate so a restart never folds in a stray byte.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      acc_reg <= 8'h00;
    end else if (en) begin
      acc_reg <= acc_reg ^ din;
    end
  end

  assign csum = acc_reg;

endmodule

// File: rtl/im_program_loader.sv
// Boot-time program loader: byte stream -> 16-bit words -> instruction-memory
// write port, with an XOR checksum gate that holds the core in reset until a
// complete, verified image is in memory.
module im_program_loader
  import im_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  input  logic              reload,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [15:0]       im_wdata,
  output logic              core_reset,
  output logic              load_done,
  output logic              err_len,
  output logic              err_csum
);

  localparam logic [WCNT_W-1:0] MAX_WORDS = max_words(ADDR_W);

  loader_state_t state_reg, state_next;

  logic [15:0]       n_reg;
  logic [7:0]        hi_reg;
  logic [WCNT_W-1:0] wcnt_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [15:0]       wdata_reg;
  logic              done_reg;
  logic              err_len_reg;
  logic              err_csum_reg;

  logic              accept;
  logic              restart;
  logic [7:0]        csum;
  logic              csum_en;
  logic [15:0]       n_full;
  logic [WCNT_W-1:0] wcnt_inc;
  logic              n_too_big;
  logic              last_word;

  // Header value as it will be once the low byte currently on the bus is taken.
  assign n_full    = {n_reg[15:8], in_byte};
  assign n_too_big = ({1'b0, n_full} > MAX_WORDS);
  assign wcnt_inc  = wcnt_reg + {{(WCNT_W-1){1'b0}}, 1'b1};
  assign last_word = (wcnt_inc == {1'b0, n_reg});

  // Only payload bytes contribute to the checksum; header and check byte do not.
  assign csum_en = accept && ((state_reg == DATA_HI) || (state_reg == DATA_LO));

  loader_csum u_csum (
    .clk   (clk),
    .reset (reset),
    .clr   (restart),
    .en    (csum_en),
    .din   (in_byte),
    .csum  (csum)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= HDR_HI;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: advance one step per accepted byte, restart on reload from a terminal state.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      HDR_HI: begin
        if (accept) state_next = HDR_LO;
      end
      HDR_LO: begin
        if (accept) begin
          if (n_too_big)             state_next = ERROR;
          else if (n_full == 16'd0)  state_next = CHECK;
          else                       state_next = DATA_HI;
        end
      end
      DATA_HI: begin
        if (accept) state_next = DATA_LO;
      end
      DATA_LO: begin
        if (accept) state_next = last_word ? CHECK : DATA_HI;
      end
      CHECK: begin
        if (accept) state_next = (in_byte == csum) ? RUN : ERROR;
      end
      RUN, ERROR: begin
        if (restart) state_next = HDR_HI;
      end
      default: state_next = HDR_HI;
    endcase
  end

  // Output decode: handshake, core reset gate and reload qualification.
  always_comb begin
    in_ready   = 1'b0;
    core_reset = 1'b1;
    restart    = 1'b0;
    case (state_reg)
      HDR_HI, HDR_LO, DATA_HI, DATA_LO, CHECK: in_ready = !reset;
      RUN: begin
        core_reset = reset;
        restart    = reload && !reset;
      end
      ERROR: restart = reload && !reset;
      default: ;
    endcase
    accept = in_valid && in_ready;
  end

  // Datapath: header capture, word assembly, registered write port and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_reg        <= 16'h0000;
      hi_reg       <= 8'h00;
      wcnt_reg     <= '0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= 16'h0000;
      done_reg     <= 1'b0;
      err_len_reg  <= 1'b0;
      err_csum_reg <= 1'b0;
    end else begin
      we_reg <= 1'b0;
      if (restart) begin
        wcnt_reg     <= '0;
        done_reg     <= 1'b0;
        err_len_reg  <= 1'b0;
        err_csum_reg <= 1'b0;
      end
      if (accept) begin
        case (state_reg)
          HDR_HI: n_reg[15:8] <= in_byte;
          HDR_LO: begin
            n_reg[7:0] <= in_byte;
            if (n_too_big) err_len_reg <= 1'b1;
          end
          DATA_HI: hi_reg <= in_byte;
          DATA_LO: begin
            we_reg    <= 1'b1;
            addr_reg  <= wcnt_reg[ADDR_W-1:0];
            wdata_reg <= {hi_reg, in_byte};
            wcnt_reg  <= wcnt_inc;
          end
          CHECK: begin
            if (in_byte == csum) done_reg     <= 1'b1;
            else                 err_csum_reg <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign im_we     = we_reg;
  assign im_addr   = addr_reg;
  assign im_wdata  = wdata_reg;
  assign load_done = done_reg;
  assign err_len   = err_len_reg;
  assign err_csum  = err_csum_reg;

endmodule
